npu_master: RTL and testbench

NPU_MASTER -- requirements
Module: npu_master

---
 rtl/npu_pkg.sv | 35 +++
 rtl/npu_master.sv | 219 +++++++++++++++++++++
 tb/tb_npu_master.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// ---------------------------------------------------------------------------
// npu_pkg
// Shared definitions for the NPU master: the job FSM state encoding, the NPU
// register map and a helper that turns the read latency into the index of
// the final wait cycle.
// ---------------------------------------------------------------------------
package npu_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_TYPE  = 3'd1,
        WR_INPUT = 3'd2,
        RD_REQ   = 3'd3,
        RD_WAIT  = 3'd4,
        RESP     = 3'd5
    } npu_state_e;

    // NPU register map
    localparam logic [31:0] TypeAddr   = 32'h0000_0000;
    localparam logic [31:0] InputAddr  = 32'h0000_0004;
    localparam logic [31:0] OutputAddr = 32'h0000_0008;

    // Value of the wait counter on the last RD_WAIT cycle. A latency of 0
    // never enters RD_WAIT, so its value is irrelevant there.
    function automatic logic [1:0] wait_last(input int unsigned lat);
        logic [1:0] last;
        if (lat == 32'd0) begin
            last = 2'd0;
        end else begin
            last = 2'(lat - 32'd1);
        end
        return last;
    endfunction

endpackage

// File: rtl/npu_master.sv
// ---------------------------------------------------------------------------
// npu_master
// Drives one NPU job per command: writes the activation-type register,
// streams the job's input words into the NPU input register, reads the
// result register back after RdLatency cycles and presents it on a
// valid/ready result port.
//
// Parameters
//   DWidth    NPU data/address word width
//   LenWidth  width of the input-word count
//   RdLatency cycles from addr_o = OutputAddr to rdata_i valid (0..3)
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o       job command handshake (type, length)
//   cmd_type_i, cmd_len_i         activation type word, input word count
//   in_valid_i/in_ready_o         input word stream handshake
//   in_data_i                     input word
//   out_valid_o/out_ready_i       result handshake
//   out_data_o                    result word read back from the NPU
//   wen_type_o, wen_input_o       NPU write strobes
//   addr_o, wdata_o, rdata_i      NPU address / write data / read data
//   busy_o                        high whenever a job is in progress
//   stall_cnt_o                   (NPU_MASTER_PERF_EN only) input stall
//                                 cycles of the current job, saturating
//
// Build option: define NPU_MASTER_PERF_EN to add the stall counter.
// ---------------------------------------------------------------------------
module npu_master
    import npu_pkg::*;
#(
    parameter int unsigned DWidth    = 32,
    parameter int unsigned LenWidth  = 8,
    parameter int unsigned RdLatency = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [DWidth-1:0]   cmd_type_i,
    input  logic [LenWidth-1:0] cmd_len_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DWidth-1:0]   in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DWidth-1:0]   out_data_o,
    output logic                wen_type_o,
    output logic                wen_input_o,
    output logic [DWidth-1:0]   addr_o,
    output logic [DWidth-1:0]   wdata_o,
    input  logic [DWidth-1:0]   rdata_i,
    output logic                busy_o
`ifdef NPU_MASTER_PERF_EN
    ,
    output logic [31:0]         stall_cnt_o
`endif
);

    localparam logic [1:0] WaitLast = wait_last(RdLatency);

    npu_state_e          state_q, state_d;
    logic [LenWidth-1:0] cnt_q, cnt_d;
    logic [DWidth-1:0]   type_q, type_d;
    logic [DWidth-1:0]   out_data_q, out_data_d;
    logic [1:0]          wait_q, wait_d;
    logic                accept_s;

    assign accept_s   = (state_q == IDLE) && cmd_valid_i;
    assign busy_o     = (state_q != IDLE);
    assign out_data_o = out_data_q;

    // Next-state and NPU bus decode for the job FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        type_d      = type_q;
        out_data_d  = out_data_q;
        wait_d      = wait_q;
        cmd_ready_o = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        wen_type_o  = 1'b0;
        wen_input_o = 1'b0;
        addr_o      = '0;
        wdata_o     = '0;

        case (state_q)
            IDLE: begin
                // Gated by reset so that every output is low while held in reset.
                cmd_ready_o = rst_ni;
                if (cmd_valid_i) begin
                    type_d  = cmd_type_i;
                    cnt_d   = cmd_len_i;
                    state_d = WR_TYPE;
                end else begin
                    state_d = IDLE;
                end
            end

            WR_TYPE: begin
                wen_type_o = 1'b1;
                addr_o     = DWidth'(TypeAddr);
                wdata_o    = type_q;
                if (cnt_q != '0) begin
                    state_d = WR_INPUT;
                end else begin
                    state_d = RD_REQ;
                end
            end

            WR_INPUT: begin
                in_ready_o = 1'b1;
                addr_o     = DWidth'(InputAddr);
                // The strobe follows in_valid_i combinationally, so each
                // accepted word reaches the NPU in its handshake cycle.
                if (in_valid_i) begin
                    wen_input_o = 1'b1;
                    wdata_o     = in_data_i;
                    cnt_d       = cnt_q - LenWidth'(1);
                    if (cnt_q == LenWidth'(1)) begin
                        state_d = RD_REQ;
                    end else begin
                        state_d = WR_INPUT;
                    end
                end else begin
                    state_d = WR_INPUT;
                end
            end

            RD_REQ: begin
                addr_o = DWidth'(OutputAddr);
                wait_d = 2'd0;
                // With zero latency the NPU answers in the request cycle.
                if (RdLatency == 32'd0) begin
                    out_data_d = rdata_i;
                    state_d    = RESP;
                end else begin
                    state_d    = RD_WAIT;
                end
            end

            RD_WAIT: begin
                // Address is held so the NPU keeps presenting the result.
                addr_o = DWidth'(OutputAddr);
                if (wait_q == WaitLast) begin
                    out_data_d = rdata_i;
                    state_d    = RESP;
                end else begin
                    wait_d     = wait_q + 2'd1;
                    state_d    = RD_WAIT;
                end
            end

            RESP: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Job FSM state, remaining word count, latched type and result registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            type_q     <= '0;
            out_data_q <= '0;
            wait_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            type_q     <= type_d;
            out_data_q <= out_data_d;
            wait_q     <= wait_d;
        end
    end

`ifdef NPU_MASTER_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Stall counter next value: cleared per job, saturating at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (accept_s) begin
            stall_cnt_d = 32'd0;
        end else if ((state_q == WR_INPUT) && !in_valid_i &&
                     (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    // accept_s only feeds the stall counter; referenced here so it is used.
    logic unused_accept_s;
    assign unused_accept_s = accept_s;
`endif

endmodule

// File: tb/tb_npu_master.sv
module tb_npu_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_type;
    logic [7:0]  cmd_len;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        wen_type, wen_input;
    logic [31:0] addr, wdata, rdata;
    logic        busy;
`ifdef NPU_MASTER_PERF_EN
    logic [31:0] stall_cnt, l0_stall, l3_stall;
`endif

    // latency-variant instances
    logic        lat_cmd_valid, lat_ready;
    logic        l0_cmd_ready, l0_in_ready, l0_out_valid, l0_wen_type, l0_wen_input, l0_busy;
    logic [31:0] l0_out_data, l0_addr, l0_wdata, l0_rdata;
    logic        l3_cmd_ready, l3_in_ready, l3_out_valid, l3_wen_type, l3_wen_input, l3_busy;
    logic [31:0] l3_out_data, l3_addr, l3_wdata, l3_rdata;

    npu_master #(.DWidth(32), .LenWidth(8), .RdLatency(1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_type_i(cmd_type), .cmd_len_i(cmd_len),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .wen_type_o(wen_type), .wen_input_o(wen_input),
        .addr_o(addr), .wdata_o(wdata), .rdata_i(rdata), .busy_o(busy)
`ifdef NPU_MASTER_PERF_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );

    npu_master #(.DWidth(32), .LenWidth(8), .RdLatency(0)) dut_l0 (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(lat_cmd_valid), .cmd_ready_o(l0_cmd_ready),
        .cmd_type_i(32'h0000_0001), .cmd_len_i(8'd0),
        .in_valid_i(1'b0), .in_ready_o(l0_in_ready), .in_data_i(32'd0),
        .out_valid_o(l0_out_valid), .out_ready_i(lat_ready), .out_data_o(l0_out_data),
        .wen_type_o(l0_wen_type), .wen_input_o(l0_wen_input),
        .addr_o(l0_addr), .wdata_o(l0_wdata), .rdata_i(l0_rdata), .busy_o(l0_busy)
`ifdef NPU_MASTER_PERF_EN
        , .stall_cnt_o(l0_stall)
`endif
    );

    npu_master #(.DWidth(32), .LenWidth(8), .RdLatency(3)) dut_l3 (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(lat_cmd_valid), .cmd_ready_o(l3_cmd_ready),
        .cmd_type_i(32'h0000_0001), .cmd_len_i(8'd0),
        .in_valid_i(1'b0), .in_ready_o(l3_in_ready), .in_data_i(32'd0),
        .out_valid_o(l3_out_valid), .out_ready_i(lat_ready), .out_data_o(l3_out_data),
        .wen_type_o(l3_wen_type), .wen_input_o(l3_wen_input),
        .addr_o(l3_addr), .wdata_o(l3_wdata), .rdata_i(l3_rdata), .busy_o(l3_busy)
`ifdef NPU_MASTER_PERF_EN
        , .stall_cnt_o(l3_stall)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // NPU model (latency 1): result = type ^ fold(inputs), fold = acc*3 + word
    logic [31:0] npu_type, npu_acc, addr_d1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            npu_type <= 32'd0; npu_acc <= 32'd0; addr_d1 <= 32'd0;
        end else begin
            addr_d1 <= addr;
            if (wen_type) begin
                npu_type <= wdata; npu_acc <= 32'd0;
            end else if (wen_input) begin
                npu_acc <= npu_acc * 32'd3 + wdata;
            end
        end
    end
    assign rdata = (addr_d1 == 32'h8) ? (npu_type ^ npu_acc) : 32'h0;

    // NPU models for the latency-0 and latency-3 instances
    logic [31:0] a3_d1, a3_d2, a3_d3;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a3_d1 <= 32'd0; a3_d2 <= 32'd0; a3_d3 <= 32'd0;
        end else begin
            a3_d1 <= l3_addr; a3_d2 <= a3_d1; a3_d3 <= a3_d2;
        end
    end
    assign l0_rdata = (l0_addr == 32'h8) ? 32'hDEAD_BEEF : 32'h0;
    assign l3_rdata = (a3_d3 == 32'h8) ? 32'hDEAD_BEEF : 32'h0;

    // scoreboards: expected NPU writes {is_type, data} and expected results
    logic [32:0] wr_q[$];
    logic [31:0] res_q[$];

    // write monitor: every strobe must match the next expected write
    always @(negedge clk) begin
        logic [32:0] e;
        if (wen_type || wen_input) begin
            check("strobe_exclusive", 32'(wen_type & wen_input), 32'd0);
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_strobe addr=%h wdata=%h expected no strobe at %0t", addr, wdata, $time);
            end else begin
                e = wr_q.pop_front();
                check("strobe_kind", 32'(wen_type), 32'(e[32]));
                check("strobe_addr", addr, e[32] ? 32'h0 : 32'h4);
                check("strobe_data", wdata, e[31:0]);
            end
        end
    end

    typedef struct {
        logic [31:0]      typ;
        logic [7:0]       len;
        logic [3:0][31:0] data;
        int               stall_at;
        int               stall_cycles;
        int               hold;
        int               exp_lat;
    } job_t;

    function automatic job_t mk(input logic [31:0] typ, input logic [7:0] len,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input int stall_at, input int stall_cycles,
                                input int hold, input int exp_lat);
        job_t j;
        j.typ = typ; j.len = len;
        j.data[0] = d0; j.data[1] = d1; j.data[2] = d2; j.data[3] = d3;
        j.stall_at = stall_at; j.stall_cycles = stall_cycles;
        j.hold = hold; j.exp_lat = exp_lat;
        return j;
    endfunction

    task automatic push_job(input job_t j);
        logic [31:0] acc;
        acc = 32'd0;
        wr_q.push_back({1'b1, j.typ});
        for (int k = 0; k < int'(j.len); k++) begin
            wr_q.push_back({1'b0, j.data[k]});
            acc = acc * 32'd3 + j.data[k];
        end
        res_q.push_back(j.typ ^ acc);
    endtask

    // feed input words (with an optional gap) until out_valid; edges counted from accept
    task automatic feed_and_wait(input job_t j, output int edges);
        int  k;
        int  stall_left;
        logic hs;
        k = 0; stall_left = j.stall_cycles; edges = 0;
        while (!out_valid && edges < 100) begin
            if (k < int'(j.len) && !(k == j.stall_at && stall_left > 0)) begin
                in_valid = 1'b1; in_data = j.data[k];
            end else begin
                in_valid = 1'b0; in_data = 32'd0;
                if (in_ready && stall_left > 0 && k == j.stall_at) stall_left--;
            end
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            edges++;
            if (hs) k++;
        end
        in_valid = 1'b0; in_data = 32'd0;
        check("out_valid_seen", 32'(out_valid), 32'd1);
        check("words_sent", 32'(k), 32'(j.len));
    endtask

    task automatic collect(input int hold);
        logic [31:0] exp_r;
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            check("hold_valid", 32'(out_valid), 32'd1);
            if (res_q.size() != 0) check("hold_data", out_data, res_q[0]);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check("out_valid", 32'(out_valid), 32'd1);
        if (res_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL result_queue actual=empty expected=entry at %0t", $time);
        end else begin
            exp_r = res_q.pop_front();
            check("out_data", out_data, exp_r);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_clear", 32'(out_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    task automatic start_cmd(input job_t j);
        push_job(j);
        cmd_valid = 1'b1; cmd_type = j.typ; cmd_len = j.len;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_type = 32'd0; cmd_len = 8'd0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        check("in_ready_wr_type", 32'(in_ready), 32'd0);
    endtask

    task automatic run_job(input job_t j);
        int edges;
        start_cmd(j);
        feed_and_wait(j, edges);
        check("latency", 32'(edges), 32'(j.exp_lat));
        collect(j.hold);
`ifdef NPU_MASTER_PERF_EN
        check("stall_cnt", stall_cnt, 32'(j.stall_cycles));
`endif
        check("writes_drained", 32'(wr_q.size()), 32'd0);
    endtask

    job_t jobs[5];

    initial begin
        job_t jb, jc;
        int   edges, e0, e3;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_type = 32'd0; cmd_len = 8'd0;
        in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        lat_cmd_valid = 1'b0; lat_ready = 1'b0;

        //             type          len   d0            d1          d2          d3     stall_at cyc hold lat
        jobs[0] = mk(32'h2,         8'd3, 32'h11,       32'h22,     32'h33,     32'h0,  -1, 0, 0,  6);
        jobs[1] = mk(32'h5,         8'd0, 32'h0,        32'h0,      32'h0,      32'h0,  -1, 0, 0,  3);
        jobs[2] = mk(32'h7,         8'd4, 32'hA1,       32'hB2,     32'hC3,     32'hD4,  2, 4, 0, 11);
        jobs[3] = mk(32'h9,         8'd1, 32'h55,       32'h0,      32'h0,      32'h0,  -1, 0, 5,  4);
        jobs[4] = mk(32'hFFFF_FFFF, 8'd2, 32'hFFFF_FFFF, 32'h1,     32'h0,      32'h0,   0, 2, 1,  7);

        // reset state
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_strobes", {30'd0, wen_type, wen_input}, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("release_cmd_ready", 32'(cmd_ready), 32'd1);
        check("release_addr", addr, 32'd0);

        for (int i = 0; i < 5; i++) run_job(jobs[i]);

        // new command waiting during a held result
        jb = mk(32'h3, 8'd2, 32'hAA, 32'hBB, 32'h0, 32'h0, -1, 0, 0, 5);
        jc = mk(32'h44, 8'd0, 32'h0, 32'h0, 32'h0, 32'h0, -1, 0, 0, 3);
        start_cmd(jb);
        feed_and_wait(jb, edges);
        check("b2b_latency_a", 32'(edges), 32'd5);
        push_job(jc);
        cmd_valid = 1'b1; cmd_type = jc.typ; cmd_len = jc.len;
        for (int h = 0; h < 5; h++) begin
            check("b2b_hold_valid", 32'(out_valid), 32'd1);
            check("b2b_hold_data", out_data, res_q[0]);
            check("b2b_hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("b2b_hold_addr", addr, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check("b2b_out_data", out_data, res_q.pop_front());
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_idle_after_hs", 32'(busy), 32'd0);
        check("b2b_ready_after_hs", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_type = 32'd0;
        check("b2b_second_accepted", 32'(busy), 32'd1);
        feed_and_wait(jc, edges);
        check("b2b_latency_b", 32'(edges), 32'd3);
        collect(0);

        // reset in the middle of the input stream
        jb = mk(32'h6, 8'd3, 32'h1, 32'h2, 32'h3, 32'h0, -1, 0, 0, 0);
        start_cmd(jb);
        in_valid = 1'b1; in_data = 32'h1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_data = 32'h2;
        check("pre_rst_strobe", 32'(wen_input), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_wen_input", 32'(wen_input), 32'd0);
        check("midrst_wen_type", 32'(wen_type), 32'd0);
        check("midrst_addr", addr, 32'd0);
        check("midrst_wdata", wdata, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        wr_q.delete(); res_q.delete();
        in_valid = 1'b0; in_data = 32'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        run_job(jobs[0]);

        // RdLatency 0 and 3 instances read 0xDEADBEEF
        lat_cmd_valid = 1'b1;
        check("lat_ready_l0", 32'(l0_cmd_ready), 32'd1);
        check("lat_ready_l3", 32'(l3_cmd_ready), 32'd1);
        @(posedge clk); #1;
        lat_cmd_valid = 1'b0;
        e0 = -1; e3 = -1;
        for (int n = 1; n <= 20 && e3 < 0; n++) begin
            @(posedge clk); #1;
            if (l0_out_valid && e0 < 0) e0 = n;
            if (l3_out_valid && e3 < 0) e3 = n;
        end
        check("lat0_latency", 32'(e0), 32'd2);
        check("lat3_latency", 32'(e3), 32'd5);
        check("lat0_data", l0_out_data, 32'hDEAD_BEEF);
        check("lat3_data", l3_out_data, 32'hDEAD_BEEF);
        lat_ready = 1'b1;
        @(posedge clk); #1;
        lat_ready = 1'b0;
        check("lat_idle", {30'd0, l0_busy, l3_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
